// File: rtl/i4004_pkg.sv
// Shared 4004 timing definitions: subcycle encoding and reset sequencer length.
package i4004_pkg;

    localparam logic [2:0] STATE_A1 = 3'd0;
    localparam logic [2:0] STATE_A2 = 3'd1;
    localparam logic [2:0] STATE_A3 = 3'd2;
    localparam logic [2:0] STATE_M1 = 3'd3;
    localparam logic [2:0] STATE_M2 = 3'd4;
    localparam logic [2:0] STATE_X1 = 3'd5;
    localparam logic [2:0] STATE_X2 = 3'd6;
    localparam logic [2:0] STATE_X3 = 3'd7;

    localparam int unsigned RESET_CYCLES = 8;

    typedef enum logic [2:0] {
        StA1 = STATE_A1,
        StA2 = STATE_A2,
        StA3 = STATE_A3,
        StM1 = STATE_M1,
        StM2 = STATE_M2,
        StX1 = STATE_X1,
        StX2 = STATE_X2,
        StX3 = STATE_X3
    } state_e;

    function automatic state_e next_state(input state_e s);
        logic [2:0] n;
        n = s + 3'd1;
        return state_e'(n);
    endfunction

endpackage

// File: rtl/i4004_phase_gen.sv
// Two-phase non-overlapping clock generator: four slots of DIV clocks per subcycle.
module i4004_phase_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic phi1_o,
    output logic phi2_o,
    output logic phi2_stb_o,
    output logic slot_end_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    // cnt_q/slot_q hold the position of the clock cycle that the next edge starts.
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    slot_q, slot_d;
    logic          phi1_q, phi1_d;
    logic          phi2_q, phi2_d;
    logic          stb_q, stb_d;
    logic          end_q, end_d;

    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        slot_d = slot_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            slot_d = slot_q + 2'd1;
        end
        phi1_d = (slot_q == 2'd0);
        phi2_d = (slot_q == 2'd2);
        stb_d  = (slot_q == 2'd2) && (cnt_q == '0);
        end_d  = (slot_q == 2'd3) && (cnt_q == CNT_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            slot_q <= 2'd0;
            phi1_q <= 1'b0;
            phi2_q <= 1'b0;
            stb_q  <= 1'b0;
            end_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
            phi1_q <= phi1_d;
            phi2_q <= phi2_d;
            stb_q  <= stb_d;
            end_q  <= end_d;
        end
    end

    assign phi1_o     = phi1_q;
    assign phi2_o     = phi2_q;
    assign phi2_stb_o = stb_q;
    assign slot_end_o = end_q;

endmodule

// File: rtl/i4004_timing.sv
// 4004 timing unit: subcycle sequencer, SYNC/address decodes and core reset sequencer.
// Define I4004_TIMING_WAIT_EN to add wait_i, which stretches M2 by whole subcycles.
module i4004_timing
    import i4004_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
`ifdef I4004_TIMING_WAIT_EN
    input  logic       wait_i,
`endif
    output logic       PHI1_o,
    output logic       PHI2_o,
    output logic       SYNC_o,
    output logic [2:0] state_o,
    output logic       phi2_stb_o,
    output logic       addr_drive_o,
    output logic       cpu_reset_o,
    output logic [7:0] instr_cnt_o
);

    localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);

    logic slot_end;

    i4004_phase_gen #(
        .DIV(DIV)
    ) u_phase_gen (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .phi1_o     (PHI1_o),
        .phi2_o     (PHI2_o),
        .phi2_stb_o (phi2_stb_o),
        .slot_end_o (slot_end)
    );

    state_e         state_q, state_d;
    logic           sync_q, sync_d;
    logic           addr_q, addr_d;
    logic           cpu_rst_q, cpu_rst_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [7:0]     instr_q, instr_d;
    logic           wrap;

    always_comb begin
        state_d   = state_q;
        cpu_rst_d = cpu_rst_q;
        rst_cnt_d = rst_cnt_q;
        instr_d   = instr_q;
        wrap      = slot_end && (state_q == StX3);

        if (slot_end) begin
            state_d = next_state(state_q);
`ifdef I4004_TIMING_WAIT_EN
            if ((state_q == StM2) && wait_i) begin
                state_d = StM2;
            end
`endif
        end

        // The X3->A1 that leaves reset starts the first counted instruction.
        if (wrap) begin
            if (cpu_rst_q) begin
                if (rst_cnt_q == RCW'(RESET_CYCLES)) begin
                    cpu_rst_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end else begin
                instr_d = instr_q + 8'd1;
            end
        end

        sync_d = (state_d != StX3);
        addr_d = (state_d == StA1) || (state_d == StA2) || (state_d == StA3);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= StX3;
            sync_q    <= 1'b0;
            addr_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
            rst_cnt_q <= '0;
            instr_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            addr_q    <= addr_d;
            cpu_rst_q <= cpu_rst_d;
            rst_cnt_q <= rst_cnt_d;
            instr_q   <= instr_d;
        end
    end

    assign state_o      = state_q;
    assign SYNC_o       = sync_q;
    assign addr_drive_o = addr_q;
    assign cpu_reset_o  = cpu_rst_q;
    assign instr_cnt_o  = instr_q;

endmodule

// File: tb/tb_i4004_timing.sv
// Directed bench for i4004_timing at DIV=2, with DIV=1 and DIV=255 instances alongside.
module tb_i4004_timing;

    logic clk;
    logic rst_n;
`ifdef I4004_TIMING_WAIT_EN
    logic wait_in;
`endif

    logic       phi1_a, phi2_a, sync_a, stb_a, addr_a, cpurst_a;
    logic [2:0] state_a;
    logic [7:0] icnt_a;
    logic       phi1_b, phi2_b, sync_b, stb_b, addr_b, cpurst_b;
    logic [2:0] state_b;
    logic [7:0] icnt_b;
    logic       phi1_c, phi2_c, sync_c, stb_c, addr_c, cpurst_c;
    logic [2:0] state_c;
    logic [7:0] icnt_c;

    int n_cmp;
    int n_bad;
    int cyc;

    i4004_timing #(.DIV(2)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
`ifdef I4004_TIMING_WAIT_EN
        .wait_i       (wait_in),
`endif
        .PHI1_o       (phi1_a),
        .PHI2_o       (phi2_a),
        .SYNC_o       (sync_a),
        .state_o      (state_a),
        .phi2_stb_o   (stb_a),
        .addr_drive_o (addr_a),
        .cpu_reset_o  (cpurst_a),
        .instr_cnt_o  (icnt_a)
    );

    i4004_timing #(.DIV(1)) dut_div1 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
`ifdef I4004_TIMING_WAIT_EN
        .wait_i       (1'b0),
`endif
        .PHI1_o       (phi1_b),
        .PHI2_o       (phi2_b),
        .SYNC_o       (sync_b),
        .state_o      (state_b),
        .phi2_stb_o   (stb_b),
        .addr_drive_o (addr_b),
        .cpu_reset_o  (cpurst_b),
        .instr_cnt_o  (icnt_b)
    );

    i4004_timing #(.DIV(255)) dut_div255 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
`ifdef I4004_TIMING_WAIT_EN
        .wait_i       (1'b0),
`endif
        .PHI1_o       (phi1_c),
        .PHI2_o       (phi2_c),
        .SYNC_o       (sync_c),
        .state_o      (state_c),
        .phi2_stb_o   (stb_c),
        .addr_drive_o (addr_c),
        .cpu_reset_o  (cpurst_c),
        .instr_cnt_o  (icnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [15:0] exp_v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (phi1_a !== 1'b0 || phi2_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_phases got phi1=%b phi2=%b want 0 0", phi1_a, phi2_a);
        end
        n_cmp++;
        if (state_a !== 3'd7) begin
            n_bad++;
            $display("FAIL reset_state got %0d want 7", state_a);
        end
        n_cmp++;
        if (sync_a !== 1'b0 || stb_a !== 1'b0 || addr_a !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_decodes got sync=%b stb=%b addr=%b want 0 0 0",
                     sync_a, stb_a, addr_a);
        end
        n_cmp++;
        if (cpurst_a !== 1'b1 || icnt_a !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_seq got cpu_reset=%b icnt=%0d want 1 0", cpurst_a, icnt_a);
        end
        exp_v = {5'b00000, 1'b1, 3'd7, 8'd0};
        n_cmp++;
        if ({phi1_b, phi2_b, sync_b, stb_b, addr_b, cpurst_b, state_b, icnt_b} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_div1 got %h want %h",
                     {phi1_b, phi2_b, sync_b, stb_b, addr_b, cpurst_b, state_b, icnt_b}, exp_v);
        end
        n_cmp++;
        if ({phi1_c, phi2_c, sync_c, stb_c, addr_c, cpurst_c, state_c, icnt_c} !== exp_v) begin
            n_bad++;
            $display("FAIL reset_div255 got %h want %h",
                     {phi1_c, phi2_c, sync_c, stb_c, addr_c, cpurst_c, state_c, icnt_c}, exp_v);
        end
    endtask

    // Releases reset at a falling edge; sample k then shows the values of clk_i cycle k.
    task automatic test_phases();
        logic [3:0] e_a, e_b;
        int m;
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            m = k % 8;
            e_a = {m < 2, m == 4 || m == 5, m == 4, 1'b0};
            n_cmp++;
            if ({phi1_a, phi2_a, stb_a} !== e_a[3:1] || state_a !== ((k < 8) ? 3'd7 : 3'd0)) begin
                n_bad++;
                $display("FAIL phases_div2 clk=%0d got p1=%b p2=%b stb=%b st=%0d want %b st=%0d",
                         k, phi1_a, phi2_a, stb_a, state_a, e_a[3:1], (k < 8) ? 7 : 0);
            end
            m = k % 4;
            e_b = {m == 0, m == 2, m == 2, 1'b0};
            n_cmp++;
            if ({phi1_b, phi2_b, stb_b} !== e_b[3:1] || state_b !== 3'((k / 4 + 7) % 8)) begin
                n_bad++;
                $display("FAIL phases_div1 clk=%0d got p1=%b p2=%b stb=%b st=%0d want %b st=%0d",
                         k, phi1_b, phi2_b, stb_b, state_b, e_b[3:1], (k / 4 + 7) % 8);
            end
            n_cmp++;
            if (phi1_c !== 1'b1 || phi2_c !== 1'b0) begin
                n_bad++;
                $display("FAIL phases_div255 clk=%0d got p1=%b p2=%b want 1 0", k, phi1_c, phi2_c);
            end
            cyc++;
        end
    endtask

    task automatic test_free_run();
        int s, n, e_icnt;
        logic [2:0] e_st;
        logic e_rst;
        while (cyc < 720) begin
            @(negedge clk);
            s = cyc / 8;
            n = (s + 7) / 8;
            e_st = 3'((s + 7) % 8);
            e_rst = (n <= 8);
            e_icnt = (n >= 9) ? n - 9 : 0;
            n_cmp++;
            if (state_a !== e_st || sync_a !== (e_st != 3'd7) || addr_a !== (e_st <= 3'd2)) begin
                n_bad++;
                $display("FAIL free_run_decode clk=%0d got st=%0d sync=%b addr=%b want st=%0d",
                         cyc, state_a, sync_a, addr_a, e_st);
            end
            n_cmp++;
            if (cpurst_a !== e_rst || icnt_a !== 8'(e_icnt)) begin
                n_bad++;
                $display("FAIL free_run_seq clk=%0d got cpu_reset=%b icnt=%0d want %b %0d",
                         cyc, cpurst_a, icnt_a, e_rst, e_icnt);
            end
            n_cmp++;
            if ((phi1_a & phi2_a) !== 1'b0 || (phi1_b & phi2_b) !== 1'b0) begin
                n_bad++;
                $display("FAIL free_run_overlap clk=%0d got a=%b%b b=%b%b want no overlap",
                         cyc, phi1_a, phi2_a, phi1_b, phi2_b);
            end
            cyc++;
        end
        n_cmp++;
        if (icnt_a !== 8'd3) begin
            n_bad++;
            $display("FAIL free_run_final_icnt got %0d want 3", icnt_a);
        end
    endtask

    task automatic test_midcycle_reset();
        int found;
        found = 0;
        for (int t = 0; t < 200 && found == 0; t++) begin
            @(negedge clk);
            if (state_a == 3'd5 && phi2_a == 1'b1) found = 1;
        end
        n_cmp++;
        if (found == 0) begin
            n_bad++;
            $display("FAIL midreset_find got no X1 PHI2 slot want one within 200 clk");
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (phi2_a !== 1'b0 || phi1_a !== 1'b0 || state_a !== 3'd7) begin
            n_bad++;
            $display("FAIL midreset_async got p1=%b p2=%b st=%0d want 0 0 7",
                     phi1_a, phi2_a, state_a);
        end
        n_cmp++;
        if (cpurst_a !== 1'b1 || icnt_a !== 8'd0 || sync_a !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_seq got cpu_reset=%b icnt=%0d sync=%b want 1 0 0",
                     cpurst_a, icnt_a, sync_a);
        end
        @(negedge clk);
        test_phases();
    endtask

    task automatic test_div_variants();
        logic pb, pc;
        int rb0, rb1, rc0, rc1, ovl;
        rb0 = -1; rb1 = -1; rc0 = -1; rc1 = -1; ovl = 0;
        pb = phi1_b;
        pc = phi1_c;
        for (int t = 0; t < 2600 && rc1 < 0; t++) begin
            @(negedge clk);
            if (phi1_b && !pb) begin
                if (rb0 < 0) rb0 = t;
                else if (rb1 < 0) rb1 = t;
            end
            if (phi1_c && !pc) begin
                if (rc0 < 0) rc0 = t;
                else if (rc1 < 0) rc1 = t;
            end
            if ((phi1_b & phi2_b) || (phi1_c & phi2_c)) ovl++;
            pb = phi1_b;
            pc = phi1_c;
        end
        n_cmp++;
        if (rb1 < 0 || rb1 - rb0 != 4) begin
            n_bad++;
            $display("FAIL div1_period got %0d want 4", rb1 - rb0);
        end
        n_cmp++;
        if (rc1 < 0 || rc1 - rc0 != 1020) begin
            n_bad++;
            $display("FAIL div255_period got %0d want 1020", rc1 - rc0);
        end
        n_cmp++;
        if (ovl != 0) begin
            n_bad++;
            $display("FAIL div_overlap got %0d overlapping clk want 0", ovl);
        end
    endtask

`ifdef I4004_TIMING_WAIT_EN
    task automatic test_wait();
        int t_a1, m2_len, after_m2, cyc_len, armed;
        logic [2:0] prev;
        t_a1 = -1; m2_len = 0; after_m2 = -1; cyc_len = -1; armed = 0;
        prev = state_a;
        for (int t = 0; t < 400 && cyc_len < 0; t++) begin
            @(negedge clk);
            if (state_a == 3'd0 && prev == 3'd7) begin
                if (t_a1 < 0) t_a1 = t;
                else if (armed != 0) cyc_len = t - t_a1;
            end
            if (t_a1 >= 0 && armed == 0 && state_a == 3'd3) begin
                wait_in = 1'b1;
                armed = 1;
            end
            if (armed != 0 && state_a == 3'd4) begin
                m2_len++;
                // Two M2 ends already sampled high; release before the third.
                if (m2_len == 17) wait_in = 1'b0;
            end
            if (armed != 0 && prev == 3'd4 && state_a != 3'd4) after_m2 = int'(state_a);
            prev = state_a;
        end
        wait_in = 1'b0;
        n_cmp++;
        if (m2_len != 24) begin
            n_bad++;
            $display("FAIL wait_m2_len got %0d want 24", m2_len);
        end
        n_cmp++;
        if (after_m2 != 5) begin
            n_bad++;
            $display("FAIL wait_next_state got %0d want 5", after_m2);
        end
        n_cmp++;
        if (cyc_len != 80) begin
            n_bad++;
            $display("FAIL wait_cycle_len got %0d want 80", cyc_len);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        rst_n = 1'b0;
`ifdef I4004_TIMING_WAIT_EN
        wait_in = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_phases();
        test_free_run();
        test_midcycle_reset();
        test_div_variants();
`ifdef I4004_TIMING_WAIT_EN
        test_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
